// File: rtl/xtlosc_freq_monitor.sv
// Crystal-oscillator frequency monitor: counts synchronized XTL_IN rising edges over
// fixed CLK gate windows and flags out-of-tolerance or lost crystal clocks.
module xtlosc_freq_monitor #(
    parameter int GATE_CYCLES = 50000,
    parameter int EXP_COUNT   = 16000,
    parameter int TOL         = 160,
    parameter int FAIL_LIMIT  = 3,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             XTL_IN,
    input  logic             ENABLE,
    input  logic             FAIL_CLR,
    output logic [CNT_W-1:0] MEAS_COUNT,
    output logic             MEAS_VALID,
    output logic             CLK_OK,
    output logic             CLK_FAIL
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int RUN_W  = (FAIL_LIMIT > 0) ? $clog2(FAIL_LIMIT + 1) : 1;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  LO_LIM    = CNT_W'(EXP_COUNT - TOL);
    localparam logic [CNT_W-1:0]  HI_LIM    = CNT_W'(EXP_COUNT + TOL);
    localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(FAIL_LIMIT);
    localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1'b1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t              state;
    logic                sync_meta;
    logic                sync_q;
    logic                xtl_prev;
    logic [GATE_W-1:0]   gate_cnt;
    logic [CNT_W-1:0]    edge_cnt;
    logic [RUN_W-1:0]    bad_run;

    logic                edge_det;
    logic                edge_inc;
    logic [CNT_W-1:0]    window_count;
    logic                in_range;
    logic [RUN_W-1:0]    bad_next;
    logic                window_end;
    logic                fail_set;

    // Synchronizer keeps running in IDLE so a re-enabled window sees no false edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            xtl_prev  <= 1'b0;
        end else begin
            sync_meta <= XTL_IN;
            sync_q    <= sync_meta;
            xtl_prev  <= sync_q;
        end
    end

    // window_count already folds in this cycle's edge, saturating at CNT_MAX.
    always_comb begin
        edge_det     = sync_q & ~xtl_prev;
        edge_inc     = edge_det & (edge_cnt != CNT_MAX);
        window_count = edge_cnt + CNT_W'(edge_inc);
        in_range     = (window_count >= LO_LIM) && (window_count <= HI_LIM);
        bad_next     = (bad_run == RUN_LIMIT) ? bad_run : (bad_run + RUN_ONE);
        window_end   = (state == MEASURE) && ENABLE && (gate_cnt == GATE_LAST);
        fail_set     = window_end && !in_range && (bad_next == RUN_LIMIT);
    end

    // Measurement FSM with registered evaluation; a new failure beats FAIL_CLR.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            bad_run    <= '0;
            MEAS_COUNT <= '0;
            MEAS_VALID <= 1'b0;
            CLK_OK     <= 1'b0;
            CLK_FAIL   <= 1'b0;
        end else begin
            MEAS_VALID <= 1'b0;
            CLK_FAIL   <= fail_set | (CLK_FAIL & ~FAIL_CLR);
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    bad_run  <= '0;
                    CLK_OK   <= 1'b0;
                    state    <= ENABLE ? MEASURE : IDLE;
                end
                MEASURE: begin
                    if (!ENABLE) begin
                        state    <= IDLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        bad_run  <= '0;
                        CLK_OK   <= 1'b0;
                    end else if (window_end) begin
                        MEAS_COUNT <= window_count;
                        MEAS_VALID <= 1'b1;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        if (in_range) begin
                            bad_run <= '0;
                            CLK_OK  <= 1'b1;
                        end else begin
                            bad_run <= bad_next;
                            CLK_OK  <= 1'b0;
                        end
                    end else begin
                        gate_cnt <= gate_cnt + GATE_ONE;
                        edge_cnt <= window_count;
                    end
                end
                default: begin
                    state    <= IDLE;
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    bad_run  <= '0;
                    CLK_OK   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xtlosc_freq_monitor.sv
// Directed bench for xtlosc_freq_monitor using scaled windows: 200-cycle gate,
// 50 +/- 5 expected edges, plus an 8-bit instance for counter saturation.
module tb_xtlosc_freq_monitor;

    logic        clk;
    logic        rst;
    logic        xtl;
    logic        enable;
    logic        fail_clr;
    logic [15:0] meas_count;
    logic        meas_valid;
    logic        clk_ok;
    logic        clk_fail;

    logic        xtl_sat;
    logic        en_sat;
    logic        clr_sat;
    logic [7:0]  sat_count;
    logic        sat_valid;
    logic        sat_ok;
    logic        sat_fail;

    int vectors;
    int miscompares;
    int phase;
    int xtl_mode;
    int pulses_left;
    int pre_delay;
    int cyc;
    logic fail_before;
    int   sat_seen;
    logic [7:0] sat_cap;
    logic sat_ok_cap;
    logic sat_fail_cap;

    xtlosc_freq_monitor #(
        .GATE_CYCLES(200), .EXP_COUNT(50), .TOL(5), .FAIL_LIMIT(3), .CNT_W(16)
    ) dut (
        .CLK(clk), .RESET(rst), .XTL_IN(xtl), .ENABLE(enable), .FAIL_CLR(fail_clr),
        .MEAS_COUNT(meas_count), .MEAS_VALID(meas_valid), .CLK_OK(clk_ok), .CLK_FAIL(clk_fail)
    );

    xtlosc_freq_monitor #(
        .GATE_CYCLES(1000), .EXP_COUNT(200), .TOL(10), .FAIL_LIMIT(3), .CNT_W(8)
    ) dut_sat (
        .CLK(clk), .RESET(rst), .XTL_IN(xtl_sat), .ENABLE(en_sat), .FAIL_CLR(clr_sat),
        .MEAS_COUNT(sat_count), .MEAS_VALID(sat_valid), .CLK_OK(sat_ok), .CLK_FAIL(sat_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One CLK cycle: advance past the edge, then drive both crystal stimuli.
    task automatic step();
        @(posedge clk);
        #1;
        phase++;
        case (xtl_mode)
            0: xtl = 1'b0;
            2: xtl = ((phase % 4) >= 2) ? 1'b1 : 1'b0;
            3: begin
                if (pre_delay > 0) begin
                    pre_delay--;
                    xtl = 1'b0;
                end else if (!xtl && pulses_left > 0) begin
                    xtl = 1'b1;
                    pulses_left--;
                end else begin
                    xtl = 1'b0;
                end
            end
            default: xtl = 1'b0;
        endcase
        xtl_sat = ~xtl_sat;
        if (sat_valid && sat_seen == 0) begin
            sat_seen     = 1;
            sat_cap      = sat_count;
            sat_ok_cap   = sat_ok;
            sat_fail_cap = sat_fail;
        end
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            fail_before = clk_fail;
            step();
            cycles++;
        end while (!meas_valid && cycles < 400);
        chk("valid_timeout", {31'b0, meas_valid}, 32'd1);
    endtask

    task automatic run_window(input int n, output int cycles);
        pulses_left = n;
        pre_delay   = 10;
        xtl_mode    = 3;
        wait_valid(cycles);
    endtask

    initial begin
        vectors = 0; miscompares = 0; phase = 0; xtl_mode = 2;
        pulses_left = 0; pre_delay = 0; sat_seen = 0;
        sat_cap = 8'd0; sat_ok_cap = 1'b0; sat_fail_cap = 1'b0; fail_before = 1'b0;
        rst = 1'b1; xtl = 1'b0; enable = 1'b0; fail_clr = 1'b0;
        xtl_sat = 1'b0; en_sat = 1'b0; clr_sat = 1'b0;

        repeat (4) step();
        chk("rst_count", {16'b0, meas_count}, 32'd0);
        chk("rst_valid", {31'b0, meas_valid}, 32'd0);
        chk("rst_ok", {31'b0, clk_ok}, 32'd0);
        chk("rst_fail", {31'b0, clk_fail}, 32'd0);
        rst = 1'b0;
        en_sat = 1'b1;
        repeat (10) step();

        // Nominal free-running crystal: exactly 50 edges in any 200-cycle window.
        enable = 1'b1;
        wait_valid(cyc);
        chk("first_latency", cyc, 32'd201);
        chk("nom1_count", {16'b0, meas_count}, 32'd50);
        chk("nom1_ok", {31'b0, clk_ok}, 32'd1);
        chk("nom1_fail", {31'b0, clk_fail}, 32'd0);
        wait_valid(cyc);
        chk("nom2_period", cyc, 32'd200);
        chk("nom2_count", {16'b0, meas_count}, 32'd50);
        chk("nom2_ok", {31'b0, clk_ok}, 32'd1);
        run_window(50, cyc);
        chk("nom3_ok", {31'b0, clk_ok}, 32'd1);
        step();
        chk("valid_pulse", {31'b0, meas_valid}, 32'd0);

        // Loss of clock: three empty windows, failure on the third.
        run_window(0, cyc);
        chk("loss1_count", {16'b0, meas_count}, 32'd0);
        chk("loss1_ok", {31'b0, clk_ok}, 32'd0);
        chk("loss1_fail", {31'b0, clk_fail}, 32'd0);
        run_window(0, cyc);
        chk("loss2_fail", {31'b0, clk_fail}, 32'd0);
        run_window(0, cyc);
        chk("loss3_count", {16'b0, meas_count}, 32'd0);
        chk("loss3_fail_before", {31'b0, fail_before}, 32'd0);
        chk("loss3_fail", {31'b0, clk_fail}, 32'd1);
        step(); fail_clr = 1'b1;
        step(); fail_clr = 1'b0;
        chk("clr_fail", {31'b0, clk_fail}, 32'd0);
        run_window(0, cyc);
        chk("refail", {31'b0, clk_fail}, 32'd1);

        // FAIL_CLR coincident with a failure-setting window end: set wins.
        step(); fail_clr = 1'b1;
        step(); fail_clr = 1'b0;
        chk("clr2_fail", {31'b0, clk_fail}, 32'd0);
        repeat (196) step();
        step(); fail_clr = 1'b1;
        chk("pre_prio_fail", {31'b0, clk_fail}, 32'd0);
        step(); fail_clr = 1'b0;
        chk("prio_valid", {31'b0, meas_valid}, 32'd1);
        chk("prio_fail", {31'b0, clk_fail}, 32'd1);

        // Recovery: a good window clears bad_run but not the sticky flag.
        run_window(50, cyc);
        chk("rec_count", {16'b0, meas_count}, 32'd50);
        chk("rec_ok", {31'b0, clk_ok}, 32'd1);
        chk("rec_sticky", {31'b0, clk_fail}, 32'd1);
        step(); fail_clr = 1'b1;
        step(); fail_clr = 1'b0;
        run_window(0, cyc);
        run_window(0, cyc);
        run_window(50, cyc);
        chk("rec2_ok", {31'b0, clk_ok}, 32'd1);
        run_window(0, cyc);
        chk("rec3_ok", {31'b0, clk_ok}, 32'd0);
        chk("rec3_fail", {31'b0, clk_fail}, 32'd0);

        // Tolerance boundaries at EXP_COUNT +/- TOL.
        run_window(55, cyc);
        chk("tol55_count", {16'b0, meas_count}, 32'd55);
        chk("tol55_ok", {31'b0, clk_ok}, 32'd1);
        run_window(45, cyc);
        chk("tol45_count", {16'b0, meas_count}, 32'd45);
        chk("tol45_ok", {31'b0, clk_ok}, 32'd1);
        run_window(56, cyc);
        chk("tol56_count", {16'b0, meas_count}, 32'd56);
        chk("tol56_ok", {31'b0, clk_ok}, 32'd0);
        run_window(44, cyc);
        chk("tol44_count", {16'b0, meas_count}, 32'd44);
        chk("tol44_ok", {31'b0, clk_ok}, 32'd0);
        chk("tol44_fail", {31'b0, clk_fail}, 32'd0);

        // ENABLE drop mid-window with bad_run at 2: partial window discarded.
        pulses_left = 0; xtl_mode = 3;
        repeat (100) step();
        enable = 1'b0;
        step();
        chk("dis_count", {16'b0, meas_count}, 32'd44);
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (meas_valid) cyc++;
        end
        chk("dis_no_valid", cyc, 32'd0);
        enable = 1'b1;
        run_window(0, cyc);
        chk("reen_latency", cyc, 32'd201);
        chk("reen_fail", {31'b0, clk_fail}, 32'd0);
        run_window(50, cyc);
        chk("reen_ok", {31'b0, clk_ok}, 32'd1);
        repeat (50) step();
        enable = 1'b0;
        step();
        chk("dis_ok_clear", {31'b0, clk_ok}, 32'd0);
        chk("dis_count_hold", {16'b0, meas_count}, 32'd50);
        enable = 1'b1;
        run_window(0, cyc);
        run_window(0, cyc);
        run_window(0, cyc);
        chk("pre_rst_fail", {31'b0, clk_fail}, 32'd1);
        run_window(50, cyc);
        chk("pre_rst_ok", {31'b0, clk_ok}, 32'd1);

        // RESET mid-window overrides everything.
        repeat (150) step();
        rst = 1'b1; enable = 1'b0;
        step();
        chk("mrst_count", {16'b0, meas_count}, 32'd0);
        chk("mrst_valid", {31'b0, meas_valid}, 32'd0);
        chk("mrst_ok", {31'b0, clk_ok}, 32'd0);
        chk("mrst_fail", {31'b0, clk_fail}, 32'd0);
        rst = 1'b0;
        step();
        step();
        enable = 1'b1;
        run_window(50, cyc);
        chk("post_rst_latency", cyc, 32'd201);
        chk("post_rst_count", {16'b0, meas_count}, 32'd50);

        // Saturation instance: 500 edges per window clamp at 255.
        chk("sat_seen", sat_seen, 32'd1);
        chk("sat_count", {24'b0, sat_cap}, 32'd255);
        chk("sat_ok", {31'b0, sat_ok_cap}, 32'd0);
        chk("sat_fail", {31'b0, sat_fail_cap}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xtlosc_freq_monitor.md
Name: xtlosc_freq_monitor

Overview:
- Consumes the 16 MHz crystal-oscillator fabric clock output (XTLOSC_O2F) as a sampled data signal, not as a clock.
- Measures its frequency against the system clock over fixed gate windows and reports each edge count.
- Flags loss of the crystal clock or an out-of-tolerance frequency so the CPU / TTC logic can fall back to the RC oscillator.
- Sits in the clock/reset area and runs on the 50 MHz RC-derived system clock.

Parameters:
- GATE_CYCLES, 50000, gate window length in CLK cycles (1 ms at 50 MHz).
- EXP_COUNT, 16000, expected rising edges per window (16 MHz).
- TOL, 160, allowed absolute deviation from EXP_COUNT (1 %).
- FAIL_LIMIT, 3, consecutive bad windows before failure is declared.
- CNT_W, 16, width of the edge counter and MEAS_COUNT.

Ports:
- CLK, input, 1, system clock. Must be more than 2x the monitored frequency.
- RESET, input, 1, synchronous active-high reset.
- XTL_IN, input, 1, crystal oscillator output; asynchronous to CLK.
- ENABLE, input, 1, run measurement when high.
- FAIL_CLR, input, 1, one-cycle pulse that clears CLK_FAIL.
- MEAS_COUNT, output, CNT_W, edge count of the last completed window.
- MEAS_VALID, output, 1, one-cycle pulse when MEAS_COUNT updates.
- CLK_OK, output, 1, last window was in range and no failure run is active.
- CLK_FAIL, output, 1, sticky failure flag.

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous and active-high. Reset values: MEAS_COUNT=0, MEAS_VALID=0, CLK_OK=0, CLK_FAIL=0. All internal counters are 0 and the FSM is in IDLE.
- Input capture: XTL_IN passes through a 2-FF synchronizer, then a registered copy. A rising edge is detected when sync=1 and the previous value was 0. Input-to-edge-detect latency is 3 CLK cycles.
- FSM states:
  - IDLE: counters held at 0. Moves to MEASURE on the cycle after ENABLE=1.
  - MEASURE: gate_cnt runs 0..GATE_CYCLES-1. edge_cnt increments on each detected edge and saturates at 2^CNT_W-1.
- Window end (cycle where gate_cnt=GATE_CYCLES-1):
  - On the next edge of CLK, MEAS_COUNT <= edge_cnt plus that cycle's edge, MEAS_VALID=1 for exactly one cycle.
  - In the same edge, gate_cnt and edge_cnt return to 0.
  - Windows run back-to-back with no dead cycle; every edge is counted in exactly one window.
- Evaluation, registered with MEAS_VALID:
  - In range means |count - EXP_COUNT| <= TOL, using unsigned compare against EXP_COUNT-TOL and EXP_COUNT+TOL.
  - In-range window: bad_run=0, CLK_OK=1.
  - Out-of-range window: CLK_OK=0, bad_run increments, saturating at FAIL_LIMIT.
  - When bad_run reaches FAIL_LIMIT, CLK_FAIL=1 in the same cycle as that window's MEAS_VALID.
- CLK_FAIL is sticky. It clears only on FAIL_CLR or RESET. If FAIL_CLR and a new failure-setting event occur in the same cycle, set wins. FAIL_CLR does not clear bad_run.
- ENABLE deassert mid-window: the next cycle returns to IDLE. The partial window is discarded with no MEAS_VALID. gate_cnt, edge_cnt, bad_run and CLK_OK clear. MEAS_COUNT and CLK_FAIL hold.
- ENABLE reassert: a fresh window starts; the synchronizer is not flushed.
- RESET mid-window: everything returns to reset values on the next edge, regardless of ENABLE.
- XTL_IN stuck at 0 or 1: count is 0, so the window is out of range.

Test Plan:
- Nominal: CLK 50 MHz, XTL_IN 16 MHz, ENABLE=1.
  - MEAS_VALID every 50000 cycles.
  - MEAS_COUNT in 15999..16001.
  - CLK_OK=1 after the first window; CLK_FAIL=0.
- Loss of clock: XTL_IN held 0 after 2 good windows.
  - MEAS_COUNT=0 on the next three windows; CLK_OK=0 from the first bad window.
  - CLK_FAIL rises in the same cycle as the third bad MEAS_VALID.
  - Then FAIL_CLR pulse -> CLK_FAIL=0, followed by CLK_FAIL=1 again at the next bad window.
- Tolerance edges: inject exactly 16160 edges per window -> CLK_OK=1. Inject 16161 -> CLK_OK=0. Inject 15840 -> CLK_OK=1. Inject 15839 -> CLK_OK=0.
- Recovery and priority:
  - Two bad windows, then one good window -> bad_run=0, CLK_FAIL stays 0.
  - FAIL_CLR asserted in the same cycle as the failure-setting MEAS_VALID -> CLK_FAIL=1.
- ENABLE/RESET mid-window:
  - ENABLE low at gate_cnt=20000 -> no MEAS_VALID, CLK_OK=0, MEAS_COUNT unchanged.
  - RESET at gate_cnt=30000 -> all outputs 0 on the next cycle; the first new MEAS_VALID comes 50000+1 cycles after ENABLE returns high.
- Saturation: bench with CNT_W=8, GATE_CYCLES=1000, XTL_IN toggling every CLK pair -> MEAS_COUNT=255, counter does not wrap.
